// File: rtl/pid_multichannel.sv
// pid_multichannel: time-multiplexed PID controller. One signed sample per
// accepted beat runs IDLE -> MUL -> SUM -> OUT on a shared datapath. Each
// channel keeps its own integrator and, optionally, its previous error.
//
// Optional feature macro: PID_MULTICHANNEL_DERIV_EN adds the derivative term
// and the per-channel previous-error storage. When it is not defined, Kd is
// ignored and latency and ports stay the same.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both 1. A source holds data/user stable while valid=1 && ready=0, and valid
// never waits on ready.
module pid_multichannel #(
  parameter int W       = 16,
  parameter int N_CH    = 4,
  parameter int FRAC    = 8,
  parameter int MAX_VAL = 32767,
  parameter int MIN_VAL = -32768,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [W-1:0]    s_axi_tdata,
  input  logic [CW-1:0]   s_axi_tuser,
  input  logic            s_axi_tvalid,
  output logic            s_axi_tready,
  input  logic [N_CH*W-1:0] Kp,
  input  logic [N_CH*W-1:0] Ki,
  input  logic [N_CH*W-1:0] Kd,
  input  logic [N_CH*W-1:0] setpoint,
  input  logic            clr,
  output logic [W-1:0]    m_axi_tdata,
  output logic [CW-1:0]   m_axi_tuser,
  output logic            m_axi_tvalid,
  input  logic            m_axi_tready,
  output logic [1:0]      dbg_state
);

  localparam int ACC_W = 3*W + 2;
  localparam logic [CW:0] N_CH_L = (CW+1)'(N_CH);
  localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(MAX_VAL);
  localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(MIN_VAL);
  localparam logic signed [2*W-1:0] I_MAX = {1'b0, {(2*W-1){1'b1}}};
  localparam logic signed [2*W-1:0] I_MIN = {1'b1, {(2*W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, SUM = 2'd2, OUT = 2'd3} state_t;

  state_t                 state;
  logic signed [W-1:0]    sample_r;
  logic [CW-1:0]          ch_r;
  logic signed [W:0]      e_r;
  logic signed [2*W-1:0]  i_new_r;
  logic signed [W-1:0]    kp_r;
  logic signed [W-1:0]    ki_r;
  logic signed [2*W-1:0]  integ [N_CH];

  logic signed [W-1:0]    sp_sel;
  logic signed [2*W-1:0]  integ_sel;
  logic signed [W:0]      e_c;
  logic [2*W:0]           i_sum;
  logic signed [2*W-1:0]  i_sat;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] shifted;
  logic [W-1:0]           u_c;

`ifdef PID_MULTICHANNEL_DERIV_EN
  logic signed [W+1:0]    d_r;
  logic signed [W-1:0]    kd_r;
  logic signed [W:0]      e_prev [N_CH];
  logic signed [W:0]      ep_sel;
  logic signed [W+1:0]    d_c;
`else
  logic unused_kd;
  assign unused_kd = ^Kd;
`endif

  // Input is only accepted in IDLE and never while reset is asserted.
  assign s_axi_tready = reset_n && (state == IDLE);
  assign dbg_state    = state;

  // MUL-stage arithmetic: error, saturated integrator update, derivative.
  always_comb begin
    sp_sel    = setpoint[int'(ch_r)*W +: W];
    integ_sel = integ[ch_r];
    e_c       = {sp_sel[W-1], sp_sel} - {sample_r[W-1], sample_r};
    i_sum     = {integ_sel[2*W-1], integ_sel} + {{W{e_c[W]}}, e_c};
    i_sat     = i_sum[2*W-1:0];
    if (i_sum[2*W] != i_sum[2*W-1]) begin
      i_sat = i_sum[2*W] ? I_MIN : I_MAX;
    end
`ifdef PID_MULTICHANNEL_DERIV_EN
    ep_sel = e_prev[ch_r];
    d_c    = {e_c[W], e_c} - {ep_sel[W], ep_sel};
`endif
  end

  // SUM-stage arithmetic: full-width accumulate, arithmetic shift, clamp.
  always_comb begin
    acc_c = ACC_W'(kp_r) * ACC_W'(e_r) + ACC_W'(ki_r) * ACC_W'(i_new_r);
`ifdef PID_MULTICHANNEL_DERIV_EN
    acc_c = acc_c + ACC_W'(kd_r) * ACC_W'(d_r);
`endif
    shifted = acc_c >>> FRAC;
    u_c     = shifted[W-1:0];
    if (shifted > MAX_A) begin
      u_c = MAX_A[W-1:0];
    end else if (shifted < MIN_A) begin
      u_c = MIN_A[W-1:0];
    end
  end

  // Control FSM, pipeline registers and per-channel state; clr wins over SUM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      m_axi_tdata  <= '0;
      m_axi_tuser  <= '0;
      m_axi_tvalid <= 1'b0;
      sample_r     <= '0;
      ch_r         <= '0;
      e_r          <= '0;
      i_new_r      <= '0;
      kp_r         <= '0;
      ki_r         <= '0;
      for (int c = 0; c < N_CH; c++) begin
        integ[c] <= '0;
      end
`ifdef PID_MULTICHANNEL_DERIV_EN
      d_r  <= '0;
      kd_r <= '0;
      for (int c = 0; c < N_CH; c++) begin
        e_prev[c] <= '0;
      end
`endif
    end else begin
      case (state)
        IDLE: begin
          // Out-of-range channel ids complete the handshake but are discarded.
          if (s_axi_tvalid && ({1'b0, s_axi_tuser} < N_CH_L)) begin
            sample_r <= s_axi_tdata;
            ch_r     <= s_axi_tuser;
            state    <= MUL;
          end
        end
        MUL: begin
          e_r     <= e_c;
          i_new_r <= i_sat;
          kp_r    <= Kp[int'(ch_r)*W +: W];
          ki_r    <= Ki[int'(ch_r)*W +: W];
`ifdef PID_MULTICHANNEL_DERIV_EN
          d_r  <= d_c;
          kd_r <= Kd[int'(ch_r)*W +: W];
`endif
          state <= SUM;
        end
        SUM: begin
          m_axi_tdata     <= u_c;
          m_axi_tuser     <= ch_r;
          m_axi_tvalid    <= 1'b1;
          integ[ch_r]     <= i_new_r;
`ifdef PID_MULTICHANNEL_DERIV_EN
          e_prev[ch_r]    <= e_r;
`endif
          state <= OUT;
        end
        OUT: begin
          if (m_axi_tready) begin
            m_axi_tvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (clr) begin
        for (int c = 0; c < N_CH; c++) begin
          integ[c] <= '0;
        end
`ifdef PID_MULTICHANNEL_DERIV_EN
        for (int c = 0; c < N_CH; c++) begin
          e_prev[c] <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pid_multichannel.sv
// tb_pid_multichannel: table-driven vectors plus hand sequences for
// backpressure, reset abort, clear and dropped channel ids. A second instance
// with five channels makes an out-of-range id (5) representable.
module tb_pid_multichannel;

  localparam int W    = 16;
  localparam int N_CH = 4;
  localparam int CW   = 2;
`ifdef PID_MULTICHANNEL_DERIV_EN
  localparam bit DERIV = 1'b1;
`else
  localparam bit DERIV = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic              reset_n = 1'b0;
  logic [W-1:0]      s_tdata = '0;
  logic [CW-1:0]     s_tuser = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [N_CH*W-1:0] kp = '0, ki = '0, kd = '0, sp = '0;
  logic              clr = 1'b0;
  logic [W-1:0]      m_tdata;
  logic [CW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [1:0]        dbg;

  pid_multichannel #(.W(W), .N_CH(N_CH), .FRAC(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_tdata(s_tdata), .s_axi_tuser(s_tuser), .s_axi_tvalid(s_tvalid), .s_axi_tready(s_tready),
    .Kp(kp), .Ki(ki), .Kd(kd), .setpoint(sp), .clr(clr),
    .m_axi_tdata(m_tdata), .m_axi_tuser(m_tuser), .m_axi_tvalid(m_tvalid), .m_axi_tready(m_tready),
    .dbg_state(dbg)
  );

  // Five-channel instance: CW=3, so channel id 5 can be driven.
  logic [W-1:0]  b_s_tdata = '0;
  logic [2:0]    b_s_tuser = '0;
  logic          b_s_tvalid = 1'b0;
  logic          b_s_tready;
  logic [5*W-1:0] b_kp = '0, b_ki = '0, b_kd = '0, b_sp = '0;
  logic [W-1:0]  b_m_tdata;
  logic [2:0]    b_m_tuser;
  logic          b_m_tvalid;
  logic [1:0]    b_dbg;

  pid_multichannel #(.W(W), .N_CH(5), .FRAC(8)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s_axi_tdata(b_s_tdata), .s_axi_tuser(b_s_tuser), .s_axi_tvalid(b_s_tvalid), .s_axi_tready(b_s_tready),
    .Kp(b_kp), .Ki(b_ki), .Kd(b_kd), .setpoint(b_sp), .clr(1'b0),
    .m_axi_tdata(b_m_tdata), .m_axi_tuser(b_m_tuser), .m_axi_tvalid(b_m_tvalid), .m_axi_tready(1'b1),
    .dbg_state(b_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model of the controller math, one state slot per channel.
  longint m_integ [N_CH];
  longint m_eprev [N_CH];

  function automatic logic [W-1:0] model(input int ch, input longint smp);
    longint e, inew, d, acc, u;
    e    = longint'($signed(sp[ch*W +: W])) - smp;
    inew = m_integ[ch] + e;
    if (inew > 64'sd2147483647) inew = 64'sd2147483647;
    if (inew < -64'sd2147483648) inew = -64'sd2147483648;
    d    = DERIV ? (e - m_eprev[ch]) : 0;
    acc  = longint'($signed(kp[ch*W +: W])) * e
         + longint'($signed(ki[ch*W +: W])) * inew
         + longint'($signed(kd[ch*W +: W])) * d;
    u    = acc >>> 8;
    if (u > 32767) u = 32767;
    if (u < -32768) u = -32768;
    m_integ[ch] = inew;
    m_eprev[ch] = e;
    return u[W-1:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_integ[c] = 0;
      m_eprev[c] = 0;
    end
  endtask

  // Scoreboard: {channel, data} and the cycle tvalid must first be seen.
  logic [CW+W-1:0] exp_q[$];
  int              lat_q[$];
  bit              prev_v = 1'b0;

  always @(negedge clk) begin
    logic [CW+W-1:0] e;
    if (m_tvalid && !prev_v) begin
      if (lat_q.size() == 0) chk("unexpected_tvalid", 1, 0);
      else chk("latency_cycle", cyc, lat_q.pop_front());
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tdata", longint'($signed(m_tdata)), longint'($signed(e[W-1:0])));
        chk("tuser", m_tuser, e[CW+W-1:W]);
      end
    end
    prev_v = m_tvalid;
  end

  // Random output backpressure while enabled.
  bit rdy_rand = 1'b0;
  always @(posedge clk) begin
    if (rdy_rand) begin
      #1 m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input int p, input int i, input int d, input int s);
    kp[ch*W +: W] = W'(p);
    ki[ch*W +: W] = W'(i);
    kd[ch*W +: W] = W'(d);
    sp[ch*W +: W] = W'(s);
  endtask

  // Present one sample; on acceptance optionally push its expectation, then
  // hold gains until the DUT has sampled them in MUL.
  task automatic send(input int ch, input int smp, input logic [W-1:0] exp, input bit push);
    bit ok = 1'b0;
    s_tdata  = W'(smp);
    s_tuser  = CW'(ch);
    s_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("s_tready_timeout", 0, 1);
    else if (push) begin
      exp_q.push_back({CW'(ch), exp});
      lat_q.push_back(cyc + 3);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      @(posedge clk);
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int ch; int smp; int p; int i; int d; int s; int exp_d; int exp_n;
  } vec_t;
  vec_t vecs [11];

  initial begin
    bit seen;
    logic [W-1:0] hold;
    vecs[0]  = '{0, 400,  256,   0,   0, 1000,    600,    600};
    vecs[1]  = '{1,   0,    0, 256,   0,  100,    100,    100};
    vecs[2]  = '{1,   0,    0, 256,   0,  100,    200,    200};
    vecs[3]  = '{1,   0,    0, 256,   0,  100,    300,    300};
    vecs[4]  = '{2,   0,  256,   0,   0,    0,      0,      0};
    vecs[5]  = '{1,   0,    0, 256,   0,  100,    400,    400};
    vecs[6]  = '{0,   0, 32767,  0,   0, 1000,  32767,  32767};
    vecs[7]  = '{0, 1000, 32767, 0,   0,    0, -32768, -32768};
    vecs[8]  = '{3,   0,    0,   0, 256,  100,    100,      0};
    vecs[9]  = '{3,   0,    0,   0, 256,  150,     50,      0};
    vecs[10] = '{2,   3,  128,   0,   0,    0,     -2,     -2};
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", s_tready, 1);
    chk("post_rst_state", dbg, 0);
    @(posedge clk); #1;

    // Table vectors
    for (int v = 0; v < 11; v++) begin
      logic [W-1:0] mv;
      set_ch(vecs[v].ch, vecs[v].p, vecs[v].i, vecs[v].d, vecs[v].s);
      mv = model(vecs[v].ch, vecs[v].smp);
      send(vecs[v].ch, vecs[v].smp, W'(DERIV ? vecs[v].exp_d : vecs[v].exp_n), 1'b1);
    end
    drain();

    // Backpressure: output held five cycles, then released
    m_tready = 1'b0;
    set_ch(2, 256, 0, 0, 50);
    hold = model(2, 0);
    send(2, 0, 16'd50, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_tvalid", m_tvalid, 1);
      chk("bp_tdata_stable", m_tdata, 50);
      chk("bp_s_tready", s_tready, 0);
    end
    @(posedge clk); #1 m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_tvalid_drop", m_tvalid, 0);
    chk("bp_idle", dbg, 0);
    chk("bp_s_tready_back", s_tready, 1);
    @(posedge clk); #1;

    // Reset during SUM aborts the transaction and clears integrators
    set_ch(1, 0, 256, 0, 100);
    s_tdata = '0; s_tuser = 2'd1; s_tvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_tready) break;
    end
    @(posedge clk); #1 s_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_sum", dbg, 2);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_s_tready_low", s_tready, 0);
    chk("abort_tvalid_low", m_tvalid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_s_tready_release", s_tready, 1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= m_tvalid;
    end
    chk("abort_no_output", seen, 0);
    model_clear();
    @(posedge clk); #1;
    hold = model(1, 0);
    send(1, 0, 16'd100, 1'b1);
    drain();

    // clr zeroes the integrator
    hold = model(1, 0);
    send(1, 0, hold, 1'b1);
    drain();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_clear();
    hold = model(1, 0);
    send(1, 0, 16'd100, 1'b1);
    drain();

    // Randomised traffic with random backpressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int ch, smp;
      logic [W-1:0] mv;
      ch  = int'($urandom_range(0, 3));
      smp = int'($urandom_range(0, 4000)) - 2000;
      set_ch(ch, int'($urandom_range(0, 1024)) - 512, int'($urandom_range(0, 128)) - 64,
             int'($urandom_range(0, 512)) - 256, int'($urandom_range(0, 4000)) - 2000);
      mv = model(ch, smp);
      send(ch, smp, mv, 1'b1);
    end
    drain();
    rdy_rand = 1'b0;
    @(posedge clk); #1 m_tready = 1'b1;

    // Out-of-range channel id on the five-channel instance is dropped
    b_kp[0 +: W] = 16'd256;
    b_sp[0 +: W] = 16'd10;
    b_s_tdata = '0; b_s_tuser = 3'd5; b_s_tvalid = 1'b1;
    @(posedge clk); #1 b_s_tvalid = 1'b0;
    chk("drop_stays_idle", b_dbg, 0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= b_m_tvalid;
    end
    chk("drop_no_output", seen, 0);
    chk("drop_s_tready", b_s_tready, 1);
    @(posedge clk); #1;
    b_s_tuser = 3'd0; b_s_tvalid = 1'b1;
    @(posedge clk); #1 b_s_tvalid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_m_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("drop_then_valid_seen", seen, 1);
    chk("drop_then_valid_tdata", b_m_tdata, 10);
    chk("drop_then_valid_tuser", b_m_tuser, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pid_multichannel.md
PID_MULTICHANNEL -- requirements
Module: pid_multichannel

Interface
REQ-001 SHALL have parameter W, default 16: signed sample, gain and output width.
REQ-002 SHALL have parameter N_CH, default 4: channels time-multiplexed on one datapath; CW = max(1, clog2(N_CH)).
REQ-003 SHALL have parameter FRAC, default 8: gain fraction bits; gains are signed Q(W-FRAC).FRAC.
REQ-004 SHALL have parameters MAX_VAL, default 32767, and MIN_VAL, default -32768: signed output clamp limits.
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports s_axi_tdata in W (signed measurement), s_axi_tuser in CW (channel id), s_axi_tvalid in 1, s_axi_tready out 1.
REQ-008 SHALL have ports Kp, Ki, Kd, setpoint, each in N_CH*W: packed per-channel values, channel c at bits [c*W +: W].
REQ-009 SHALL have port clr  in  1  zeroes integrator and previous error of all channels.
REQ-010 SHALL have ports m_axi_tdata out W (signed control output), m_axi_tuser out CW (channel id), m_axi_tvalid out 1, m_axi_tready in 1.

Function
REQ-011 SHALL use FSM IDLE -> MUL -> SUM -> OUT -> IDLE; s_axi_tready = 1 only in IDLE.
REQ-012 SHALL capture sample and channel on an IDLE handshake (cycle 0); m_axi_tvalid rises at cycle 3; fixed latency.
REQ-013 MUL: e = setpoint[ch] - sample (W+1 bits signed); I' = sat(I[ch] + e) at 2W bits signed; d = e - e_prev[ch] (W+2 bits).
REQ-014 SUM: acc = Kp*e + Ki*I' + Kd*d at full width (3W+2 bits), no intermediate truncation.
REQ-015 SHALL compute u = acc >>> FRAC (arithmetic), clamped to [MIN_VAL, MAX_VAL], registered on m_axi_tdata.
REQ-016 I[ch] and e_prev[ch] SHALL update in SUM only; other channels unchanged.
REQ-017 OUT SHALL hold m_axi_tdata/tuser stable while m_axi_tvalid=1 and m_axi_tready=0; on handshake -> IDLE, m_axi_tvalid=0 next cycle.
REQ-018 Channel id >= N_CH SHALL be accepted and dropped: no output, no state update, stays in IDLE.
REQ-019 clr SHALL take priority over a same-cycle SUM update; the in-flight result still emits using pre-clear values.
REQ-020 Gain/setpoint changes SHALL take effect at the next MUL cycle; values sampled in MUL only.

Reset
REQ-021 reset_n=0 at a clock edge SHALL force IDLE, all I and e_prev to 0, m_axi_tdata=0, m_axi_tuser=0, m_axi_tvalid=0.
REQ-022 s_axi_tready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.
REQ-023 Reset mid-operation SHALL abort the transaction without emitting output.

Configuration
REQ-024 Macro PID_MULTICHANNEL_DERIV_EN defined: derivative term and e_prev storage present per REQ-013/014.
REQ-025 Macro undefined: Kd ignored, d term = 0, no e_prev storage; latency and interface unchanged.

Verification (W=16, N_CH=4, FRAC=8)
REQ-026 Ch0 Kp=256, Ki=Kd=0, setpoint=1000, sample=400 -> m_axi_tdata=600, tuser=0, tvalid at cycle 3.
REQ-027 Ch1 Kp=0, Ki=256, setpoint=100, samples 0,0,0 -> outputs 100,200,300; then a ch2 sample leaves ch1 I=300.
REQ-028 Ch0 Kp=32767, error 1000 -> output 32767; error -1000 -> -32768.
REQ-029 DERIV_EN, ch3 Kp=Ki=0, Kd=256, errors 100 then 150 -> outputs 100, 50; without macro -> 0, 0.
REQ-030 m_axi_tready=0 for 5 cycles in OUT -> tdata stable, s_axi_tready=0; then release -> handshake, IDLE next cycle.
REQ-031 reset_n=0 during SUM -> no output, ch integrator 0, s_axi_tready=1 after release; channel id 5 -> no output.
